// File: rtl/uart_frame_buf_if.sv
// uart_frame_buf_if: receive/transmit byte handshake and frame status bundle for uart_frame_buf
interface uart_frame_buf_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W = 5
);
  logic [DATA_W-1:0] rx_data;
  logic rx_data_vld;
  logic send_req;
  logic tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic tx_data_vld;
  logic [LEN_W-1:0] frame_len;
  logic busy;
  logic frame_ready;
  logic rx_drop;
  logic frame_done;
  modport master (
    output rx_data, rx_data_vld, send_req, tx_ready,
    input tx_data, tx_data_vld, frame_len, busy, frame_ready, rx_drop, frame_done
  );
  modport slave (
    input rx_data, rx_data_vld, send_req, tx_ready,
    output tx_data, tx_data_vld, frame_len, busy, frame_ready, rx_drop, frame_done
  );
endinterface

// File: rtl/uart_frame_buf.sv
// uart_frame_buf: collects received bytes into a frame and replays it through the uart_tx handshake
module uart_frame_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16,
  parameter int TERM_EN = 1,
  parameter logic [DATA_W-1:0] TERM_CHAR = 'h0D,
  parameter int AUTO_SEND = 1,
  localparam int LEN_W = $clog2(DEPTH + 1),
  localparam int RI_W = $clog2(DEPTH)
) (
  input logic clk,
  input logic rst,
  uart_frame_buf_if.slave bus
);
  typedef enum logic [2:0] {RECV, HOLD, SEND, WAIT_LO, WAIT_HI} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [LEN_W-1:0] len, len_nx, len_inc;
  logic [RI_W-1:0] rd, rd_nx;
  logic [DATA_W-1:0] tx_q, tx_nx;
  logic vld_q, vld_nx, drop_q, drop_nx, done_q, done_nx;
  logic store, closes, last;
  assign store = state == RECV && bus.rx_data_vld;
  assign len_inc = len + LEN_W'(1);
  assign closes = store && (len_inc == LEN_W'(DEPTH) || (TERM_EN != 0 && bus.rx_data == TERM_CHAR));
  assign last = LEN_W'(rd) == len - LEN_W'(1);
  always_comb begin
    state_nx = state;
    len_nx = store ? len_inc : len;
    rd_nx = rd;
    tx_nx = tx_q;
    vld_nx = 1'b0;
    drop_nx = bus.rx_data_vld && state != RECV;
    done_nx = 1'b0;
    case (state)
      RECV: state_nx = ((bus.send_req && (store || len != '0)) || (closes && AUTO_SEND != 0)) ? SEND
                     : closes ? HOLD : RECV;
      HOLD: state_nx = bus.send_req ? SEND : HOLD;
      SEND: begin
        state_nx = bus.tx_ready ? WAIT_LO : SEND;
        vld_nx = bus.tx_ready;
        tx_nx = bus.tx_ready ? mem[rd] : tx_q;
      end
      WAIT_LO: state_nx = bus.tx_ready ? WAIT_LO : WAIT_HI;
      WAIT_HI: begin
        state_nx = !bus.tx_ready ? WAIT_HI : last ? RECV : SEND;
        done_nx = bus.tx_ready && last;
        len_nx = (bus.tx_ready && last) ? '0 : len;
        rd_nx = !bus.tx_ready ? rd : last ? '0 : rd + RI_W'(1);
      end
      default: state_nx = RECV;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RECV;
      len <= '0;
      rd <= '0;
      tx_q <= '0;
      vld_q <= 1'b0;
      drop_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state <= state_nx;
      len <= len_nx;
      rd <= rd_nx;
      tx_q <= tx_nx;
      vld_q <= vld_nx;
      drop_q <= drop_nx;
      done_q <= done_nx;
    end
  end
  always_ff @(posedge clk) begin
    if (store) mem[len[RI_W-1:0]] <= bus.rx_data;
  end
  assign bus.tx_data = tx_q;
  assign bus.tx_data_vld = vld_q;
  assign bus.frame_len = len;
  assign bus.busy = state inside {SEND, WAIT_LO, WAIT_HI};
  assign bus.frame_ready = state == HOLD;
  assign bus.rx_drop = drop_q;
  assign bus.frame_done = done_q;
endmodule

// File: tb/tb_uart_frame_buf.sv
// tb_uart_frame_buf: three configurations driven with shared stimulus, each compared every cycle
// against a frame-level reference model; a stub uart_tx per instance supplies tx_ready.
module tb_uart_frame_buf;
  localparam int N = 3;
  localparam int DEP [N] = '{16, 16, 4};
  localparam int TRM [N] = '{1, 1, 0};
  localparam int AUT [N] = '{1, 0, 1};
  localparam int M_RX = 0, M_HOLD = 1, M_TX = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic rx_vld = 1'b0;
  logic send_req = 1'b0;
  logic ready [N];
  always #5 clk = ~clk;
  uart_frame_buf_if #(.DATA_W(8), .LEN_W(5)) b0 ();
  uart_frame_buf_if #(.DATA_W(8), .LEN_W(5)) b1 ();
  uart_frame_buf_if #(.DATA_W(8), .LEN_W(3)) b2 ();
  uart_frame_buf #(.DEPTH(16), .TERM_EN(1), .AUTO_SEND(1)) u0 (.clk(clk), .rst(rst), .bus(b0));
  uart_frame_buf #(.DEPTH(16), .TERM_EN(1), .AUTO_SEND(0)) u1 (.clk(clk), .rst(rst), .bus(b1));
  uart_frame_buf #(.DEPTH(4), .TERM_EN(0), .AUTO_SEND(1)) u2 (.clk(clk), .rst(rst), .bus(b2));
  assign b0.rx_data = rx_data;
  assign b1.rx_data = rx_data;
  assign b2.rx_data = rx_data;
  assign b0.rx_data_vld = rx_vld;
  assign b1.rx_data_vld = rx_vld;
  assign b2.rx_data_vld = rx_vld;
  assign b0.send_req = send_req;
  assign b1.send_req = send_req;
  assign b2.send_req = send_req;
  assign b0.tx_ready = ready[0];
  assign b1.tx_ready = ready[1];
  assign b2.tx_ready = ready[2];
  logic [7:0] o_data [N];
  logic [4:0] o_len [N];
  logic o_vld [N], o_busy [N], o_rdy [N], o_drop [N], o_done [N];
  assign o_data = '{b0.tx_data, b1.tx_data, b2.tx_data};
  assign o_len = '{b0.frame_len, b1.frame_len, 5'(b2.frame_len)};
  assign o_vld = '{b0.tx_data_vld, b1.tx_data_vld, b2.tx_data_vld};
  assign o_busy = '{b0.busy, b1.busy, b2.busy};
  assign o_rdy = '{b0.frame_ready, b1.frame_ready, b2.frame_ready};
  assign o_drop = '{b0.rx_drop, b1.rx_drop, b2.rx_drop};
  assign o_done = '{b0.frame_done, b1.frame_done, b2.frame_done};
  int mode [N], mlen [N], sent [N], cnt [N];
  int n_vld [N], n_drop [N], n_done [N];
  bit inflight [N], lo_seen [N];
  logic [7:0] mbuf [N][16];
  logic [7:0] e_data [N];
  logic e_vld [N], e_drop [N], e_done [N];
  int tx_lat = 10;
  int n_cmp = 0, n_bad = 0;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // Frame-level model: the buffer is an array filled in order, transmission walks it with a count
  task automatic model_step(int k);
    bit closes = 1'b0;
    e_vld[k] = 1'b0;
    e_drop[k] = 1'b0;
    e_done[k] = 1'b0;
    if (rst) begin
      mode[k] = M_RX;
      mlen[k] = 0;
      e_data[k] = 8'h00;
      inflight[k] = 1'b0;
    end else if (mode[k] == M_RX) begin
      if (rx_vld) begin
        mbuf[k][mlen[k]] = rx_data;
        mlen[k]++;
        closes = mlen[k] == DEP[k] || (TRM[k] != 0 && rx_data == 8'h0D);
      end
      if ((send_req && mlen[k] > 0) || (closes && AUT[k] != 0)) begin
        mode[k] = M_TX;
        sent[k] = 0;
        inflight[k] = 1'b0;
      end else if (closes) mode[k] = M_HOLD;
    end else begin
      e_drop[k] = rx_vld;
      if (mode[k] == M_HOLD) begin
        if (send_req) begin
          mode[k] = M_TX;
          sent[k] = 0;
          inflight[k] = 1'b0;
        end
      end else if (!inflight[k]) begin
        if (ready[k]) begin
          e_vld[k] = 1'b1;
          e_data[k] = mbuf[k][sent[k]];
          sent[k]++;
          inflight[k] = 1'b1;
          lo_seen[k] = 1'b0;
        end
      end else if (!lo_seen[k]) lo_seen[k] = !ready[k];
      else if (ready[k]) begin
        inflight[k] = 1'b0;
        if (sent[k] == mlen[k]) begin
          e_done[k] = 1'b1;
          mlen[k] = 0;
          mode[k] = M_RX;
        end
      end
    end
  endtask
  task automatic cycle(bit r, bit v, logic [7:0] d, bit s);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      check($sformatf("frame_len[%0d]", k), 32'(o_len[k]), 32'(mlen[k]));
      check($sformatf("tx_data_vld[%0d]", k), 32'(o_vld[k]), 32'(e_vld[k]));
      check($sformatf("tx_data[%0d]", k), 32'(o_data[k]), 32'(e_data[k]));
      check($sformatf("rx_drop[%0d]", k), 32'(o_drop[k]), 32'(e_drop[k]));
      check($sformatf("frame_done[%0d]", k), 32'(o_done[k]), 32'(e_done[k]));
      check($sformatf("busy[%0d]", k), 32'(o_busy[k]), 32'(mode[k] == M_TX));
      check($sformatf("frame_ready[%0d]", k), 32'(o_rdy[k]), 32'(mode[k] == M_HOLD));
      n_vld[k] += int'(o_vld[k] === 1'b1);
      n_drop[k] += int'(o_drop[k] === 1'b1);
      n_done[k] += int'(o_done[k] === 1'b1);
      if (o_vld[k] === 1'b1) cnt[k] = tx_lat > 0 ? tx_lat : int'($urandom_range(1, 12));
      ready[k] = cnt[k] == 0;
      if (cnt[k] > 0) cnt[k]--;
    end
    rst = r;
    rx_vld = v;
    rx_data = d;
    send_req = s;
    for (int k = 0; k < N; k++) model_step(k);
  endtask
  task automatic idle(int n);
    repeat (n) cycle(1'b0, 1'b0, 8'h00, 1'b0);
  endtask
  task automatic send_str(string s);
    for (int i = 0; i < s.len(); i++) cycle(1'b0, 1'b1, s[i], 1'b0);
  endtask
  task automatic clear_counts();
    for (int k = 0; k < N; k++) begin
      n_vld[k] = 0;
      n_drop[k] = 0;
      n_done[k] = 0;
    end
  endtask
  initial begin
    for (int k = 0; k < N; k++) begin
      ready[k] = 1'b1;
      cnt[k] = 0;
      mode[k] = M_RX;
      mlen[k] = 0;
      e_data[k] = 8'h00;
      e_vld[k] = 1'b0;
      e_drop[k] = 1'b0;
      e_done[k] = 1'b0;
    end
    repeat (2) cycle(1'b1, 1'b0, 8'h00, 1'b0);
    idle(2);
    clear_counts();
    send_str("HELLO");
    cycle(1'b0, 1'b1, 8'h0D, 1'b0);
    idle(150);
    check("hello_bytes_auto", n_vld[0], 6);
    check("hello_done_auto", n_done[0], 1);
    check("hello_bytes_manual", n_vld[1], 0);
    check("hello_bytes_depth4", n_vld[2], 4);
    check("hello_drops_depth4", n_drop[2], 2);
    check("hold_frame_ready", 32'(o_rdy[1]), 1);
    check("hold_busy", 32'(o_busy[1]), 0);
    clear_counts();
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    idle(150);
    check("hold_send_bytes", n_vld[1], 6);
    clear_counts();
    send_str("ABC");
    idle(5);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    idle(150);
    for (int k = 0; k < N; k++) check($sformatf("abc_bytes[%0d]", k), n_vld[k], 3);
    clear_counts();
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    idle(20);
    for (int k = 0; k < N; k++) check($sformatf("empty_send[%0d]", k), n_vld[k], 0);
    clear_counts();
    for (int i = 1; i <= 5; i++) cycle(1'b0, 1'b1, 8'(i), 1'b0);
    idle(150);
    check("full_bytes", n_vld[2], 4);
    check("full_drop", n_drop[2], 1);
    check("full_done", n_done[2], 1);
    check("full_last", 32'(o_data[2]), 32'h04);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    idle(150);
    clear_counts();
    send_str("qr");
    cycle(1'b0, 1'b1, 8'h7A, 1'b1);
    idle(150);
    for (int k = 0; k < N; k++) begin
      check($sformatf("same_cycle_bytes[%0d]", k), n_vld[k], 3);
      check($sformatf("same_cycle_last[%0d]", k), 32'(o_data[k]), 32'h7A);
    end
    send_str("abcdefg");
    cycle(1'b0, 1'b1, 8'h0D, 1'b0);
    idle(20);
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    clear_counts();
    idle(40);
    for (int k = 0; k < N; k++) check($sformatf("post_reset_vld[%0d]", k), n_vld[k], 0);
    send_str("Z");
    cycle(1'b0, 1'b1, 8'h0D, 1'b0);
    idle(60);
    check("post_reset_frame", n_vld[0], 2);
    check("post_reset_len4", 32'(o_len[2]), 2);
    tx_lat = 0;
    repeat (4000)
      cycle(($urandom % 1500) == 0, ($urandom % 4) == 0,
            ($urandom % 6) == 0 ? 8'h0D : 8'($urandom), ($urandom % 40) == 0);
    idle(200);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
